// File: rtl/matrix_mul_gen_pkg.sv
// Shared types and width helpers for the parametrised signed matrix multiplier.
package matrix_mul_gen_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        CALC   = 3'd3,
        WRITE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    function automatic int sz_w(input int max_n);
        return $clog2(max_n + 1);
    endfunction

    function automatic int cnt_w(input int max_n);
        return $clog2(max_n * max_n + 1);
    endfunction

    function automatic int acc_w(input int data_w, input int max_n);
        return 2 * data_w + $clog2(max_n);
    endfunction

    // Index width for the MAX_N*MAX_N element arrays; never narrower than 1 bit.
    function automatic int addr_w(input int max_n);
        return (max_n > 1) ? $clog2(max_n * max_n) : 1;
    endfunction

endpackage

// File: rtl/matrix_mul_gen_if.sv
// Single-stream element handshake: one read port for A/B, one write strobe for C.
interface matrix_mul_gen_if #(
    parameter int DATA_W = 16
) ();
    logic signed [DATA_W-1:0] rdata;
    logic                     ren;
    logic                     raddr;
    logic signed [DATA_W-1:0] wdata;
    logic                     wen;

    modport master (input rdata, output ren, raddr, wdata, wen);
    modport slave  (output rdata, input ren, raddr, wdata, wen);
endinterface

// File: rtl/mm_mac_sat.sv
// Signed multiply-accumulate with clear/enable and a saturating or truncating output formatter.
module mm_mac_sat #(
    parameter int DATA_W = 16,
    parameter int ACC_W  = 35
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clr,
    input  logic                     en,
    input  logic                     sat_en,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] fmt_next
);
    localparam logic signed [ACC_W-1:0] POS_MAX = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] NEG_MIN = ~POS_MAX;

    function automatic logic signed [DATA_W-1:0] fmt(input logic signed [ACC_W-1:0] v,
                                                     input logic sat);
        if (sat && (v > POS_MAX)) return POS_MAX[DATA_W-1:0];
        if (sat && (v < NEG_MIN)) return NEG_MIN[DATA_W-1:0];
        return v[DATA_W-1:0];
    endfunction

    logic signed [2*DATA_W-1:0] prod_p0;
    logic signed [ACC_W-1:0]    sum_p0;
    logic signed [ACC_W-1:0]    acc_p1;

    assign prod_p0  = (2*DATA_W)'(a) * (2*DATA_W)'(b);
    assign sum_p0   = acc_p1 + ACC_W'(prod_p0);
    // The formatter sees the sum including the current product, so the last term lands in the write.
    assign fmt_next = fmt(sum_p0, sat_en);

    // Stage p0 -> p1: accumulator register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            acc_p1 <= '0;
        end else if (clr) begin
            acc_p1 <= '0;
        end else if (en) begin
            acc_p1 <= sum_p0;
        end
    end

endmodule

// File: rtl/matrix_mul_gen.sv
// C = A*B for signed N x N matrices (N <= MAX_N), streamed in over one read port and out over one write strobe.
module matrix_mul_gen
    import matrix_mul_gen_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int MAX_N  = 8,
    parameter int SZ_W   = sz_w(MAX_N),
    parameter int CNT_W  = cnt_w(MAX_N),
    parameter int ACC_W  = acc_w(DATA_W, MAX_N)
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start,
    input  logic [SZ_W-1:0]  sizes,
    input  logic             sat_en,
    matrix_mul_gen_if.master bus,
    output logic             finish,
    output logic             busy,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] input_data_num,
    output logic [CNT_W-1:0] out_data_num
);
    localparam int AW = addr_w(MAX_N);

    state_t                   cur_state;
    logic [SZ_W-1:0]          n, i, j, m, n_clamp;
    logic [CNT_W-1:0]         nn, k;
    logic                     sat_lat, read_en, read_sel, write_en;
    logic                     last_k, last_m, last_elem;
    logic [AW-1:0]            a_idx, b_idx;
    logic signed [DATA_W-1:0] write_data, a_op, b_op, fmt_next;
    logic signed [DATA_W-1:0] a_mem [MAX_N*MAX_N];
    logic signed [DATA_W-1:0] b_mem [MAX_N*MAX_N];

    assign n_clamp   = (sizes > SZ_W'(MAX_N)) ? SZ_W'(MAX_N) : sizes;
    assign last_k    = (k == nn - CNT_W'(1));
    assign last_m    = (m == n - SZ_W'(1));
    assign last_elem = (i == n - SZ_W'(1)) && (j == n - SZ_W'(1));
    // Both arrays are packed row-major with stride N, not MAX_N.
    assign a_idx     = AW'(CNT_W'(i) * CNT_W'(n) + CNT_W'(m));
    assign b_idx     = AW'(CNT_W'(m) * CNT_W'(n) + CNT_W'(j));
    assign a_op      = a_mem[a_idx];
    assign b_op      = b_mem[b_idx];

    assign bus.ren   = read_en;
    assign bus.raddr = read_sel;
    assign bus.wen   = write_en;
    assign bus.wdata = write_data;
    assign state     = cur_state;

    always_ff @(posedge clk) begin
        if (cur_state == LOAD_A && read_en) a_mem[AW'(k)] <= bus.rdata;
        if (cur_state == LOAD_B)            b_mem[AW'(k)] <= bus.rdata;
    end

    mm_mac_sat #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
        .clk      (clk),
        .rstn     (rstn),
        .clr      (cur_state != CALC),
        .en       (cur_state == CALC),
        .sat_en   (sat_lat),
        .a        (a_op),
        .b        (b_op),
        .fmt_next (fmt_next)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cur_state      <= IDLE;
            read_en        <= 1'b0;
            read_sel       <= 1'b0;
            write_en       <= 1'b0;
            write_data     <= '0;
            finish         <= 1'b0;
            busy           <= 1'b0;
            input_data_num <= '0;
            out_data_num   <= '0;
            n              <= '0;
            nn             <= '0;
            k              <= '0;
            i              <= '0;
            j              <= '0;
            m              <= '0;
            sat_lat        <= 1'b0;
        end else begin
            case (cur_state)
                IDLE: if (start) begin
                    n              <= n_clamp;
                    nn             <= CNT_W'(n_clamp) * CNT_W'(n_clamp);
                    sat_lat        <= sat_en;
                    k              <= '0;
                    i              <= '0;
                    j              <= '0;
                    m              <= '0;
                    input_data_num <= '0;
                    out_data_num   <= '0;
                    busy           <= 1'b1;
                    if (n_clamp == '0) begin
                        cur_state <= DONE;
                        finish    <= 1'b1;
                    end else begin
                        cur_state <= LOAD_A;
                    end
                end
                // The first LOAD_A cycle only raises ren; captures start on the next edge.
                LOAD_A: if (!read_en) begin
                    read_en <= 1'b1;
                end else begin
                    if (last_k) begin
                        k              <= '0;
                        read_sel       <= 1'b1;
                        input_data_num <= '0;
                        cur_state      <= LOAD_B;
                    end else begin
                        k              <= k + CNT_W'(1);
                        input_data_num <= k + CNT_W'(1);
                    end
                end
                LOAD_B: begin
                    input_data_num <= k + CNT_W'(1);
                    if (last_k) begin
                        k         <= '0;
                        read_en   <= 1'b0;
                        read_sel  <= 1'b0;
                        cur_state <= CALC;
                    end else begin
                        k <= k + CNT_W'(1);
                    end
                end
                CALC: if (last_m) begin
                    m            <= '0;
                    write_en     <= 1'b1;
                    write_data   <= fmt_next;
                    out_data_num <= out_data_num + CNT_W'(1);
                    cur_state    <= WRITE;
                end else begin
                    m <= m + SZ_W'(1);
                end
                WRITE: begin
                    write_en <= 1'b0;
                    if (last_elem) begin
                        finish    <= 1'b1;
                        cur_state <= DONE;
                    end else begin
                        cur_state <= CALC;
                        if (j == n - SZ_W'(1)) begin
                            j <= '0;
                            i <= i + SZ_W'(1);
                        end else begin
                            j <= j + SZ_W'(1);
                        end
                    end
                end
                DONE: begin
                    finish    <= 1'b0;
                    busy      <= 1'b0;
                    cur_state <= IDLE;
                end
                default: cur_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matrix_mul_gen.sv
// Bench for matrix_mul_gen: table of 1x1 format cases plus scoreboarded multi-element runs.
module tb_matrix_mul_gen;
    localparam int DATA_W = 16;
    localparam int MAX_N  = 8;
    localparam int SZ_W   = 4;
    localparam int CNT_W  = 7;

    logic             clk = 1'b0, rstn = 1'b0, start = 1'b0, sat_en = 1'b0;
    logic [SZ_W-1:0]  sizes = '0;
    logic             finish, busy;
    logic [2:0]       state;
    logic [CNT_W-1:0] input_data_num, out_data_num;

    matrix_mul_gen_if #(.DATA_W(DATA_W)) bus ();

    matrix_mul_gen #(.DATA_W(DATA_W), .MAX_N(MAX_N)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .start          (start),
        .sizes          (sizes),
        .sat_en         (sat_en),
        .bus            (bus),
        .finish         (finish),
        .busy           (busy),
        .state          (state),
        .input_data_num (input_data_num),
        .out_data_num   (out_data_num)
    );

    always #5 clk = ~clk;

    typedef struct {
        int a;
        int b;
        bit sat;
        int exp;
    } vec_t;

    int checks = 0, errors = 0, cyc = 0;
    int sb[$];
    int a_cur[64], b_cur[64], a_nxt[64], b_nxt[64];
    int ak = 0, bk = 0, ren_cnt = 0, wen_cnt = 0, last_wen = -1, cur_n = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    // Memory model: serves A or B in row-major order while ren is high, junk otherwise.
    always @(negedge clk) begin
        if (bus.ren) begin
            ren_cnt++;
            if (bus.raddr) begin
                bus.rdata = 16'(b_cur[bk % 64]);
                bk++;
            end else begin
                bus.rdata = 16'(a_cur[ak % 64]);
                ak++;
            end
        end else begin
            bus.rdata = 16'($urandom);
        end
    end

    always @(negedge clk) begin
        if (bus.wen) begin
            wen_cnt++;
            if (last_wen >= 0) chk("wen_gap", cyc - last_wen, cur_n + 1);
            last_wen = cyc;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL wen_unexpected wdata=%0d while no result was expected", bus.wdata);
            end else begin
                chk("wdata", int'(bus.wdata), sb.pop_front());
            end
        end
        if (finish) last_wen = -1;
    end

    function automatic int fmt(input longint v, input bit sat);
        if (sat) begin
            if (v > 32767) return 32767;
            if (v < -32768) return -32768;
            return int'(v);
        end
        v = v & 64'hFFFF;
        if (v >= 32768) v = v - 65536;
        return int'(v);
    endfunction

    function automatic void push_model(input int n, input bit sat, input int a[64], input int b[64]);
        for (int r = 0; r < n; r++)
            for (int c = 0; c < n; c++) begin
                longint acc = 0;
                for (int t = 0; t < n; t++) acc += longint'(a[r*n+t]) * longint'(b[t*n+c]);
                sb.push_back(fmt(acc, sat));
            end
    endfunction

    task automatic fill_rand(output int a[64], output int b[64]);
        for (int x = 0; x < 64; x++) begin
            a[x] = int'($urandom_range(200)) - 100;
            b[x] = int'($urandom_range(200)) - 100;
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_ren"}, bus.ren, 0);
        chk({tag, "_raddr"}, bus.raddr, 0);
        chk({tag, "_wen"}, bus.wen, 0);
        chk({tag, "_finish"}, finish, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_wdata"}, bus.wdata, 0);
        chk({tag, "_in_num"}, input_data_num, 0);
        chk({tag, "_out_num"}, out_data_num, 0);
    endtask

    task automatic run_mm(input int sz, input bit sat, input string tag);
        int n, lat, t0, cnt;
        bit got;
        n = (sz > MAX_N) ? MAX_N : sz;
        cur_n = n; ak = 0; bk = 0; ren_cnt = 0; wen_cnt = 0; last_wen = -1;
        @(negedge clk);
        sizes = SZ_W'(sz); sat_en = sat; start = 1'b1; t0 = cyc + 1;
        @(posedge clk); #1;
        start = 1'b0; sizes = 4'd5; sat_en = ~sat;
        chk({tag, "_state0"}, state, (n == 0) ? 5 : 1);
        chk({tag, "_busy"}, busy, 1);
        got = 0; cnt = 0; lat = 0;
        while (!got && cnt < 3000) begin
            @(negedge clk);
            cnt++;
            if (finish) begin got = 1; lat = cyc - t0; end
        end
        chk({tag, "_finished"}, got, 1);
        if (n == 0) chk({tag, "_lat_within2"}, (lat <= 2), 1);
        else        chk({tag, "_latency"}, lat, 2*n*n + n*n*(n+1) + 1);
        chk({tag, "_ren_cycles"}, ren_cnt, 2*n*n);
        chk({tag, "_wen_count"}, wen_cnt, n*n);
        chk({tag, "_out_num"}, out_data_num, n*n);
        chk({tag, "_in_num"}, input_data_num, n*n);
        chk({tag, "_sb_left"}, sb.size(), 0);
        @(negedge clk);
        chk({tag, "_finish_1cyc"}, finish, 0);
        chk({tag, "_idle"}, busy, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        vec_t tbl[9];
        int cnt, fin1, fin2, fins;
        bit got;
        tbl[0] = '{32767, 2, 1'b1, 32767};
        tbl[1] = '{32767, 2, 1'b0, -2};
        tbl[2] = '{-32768, 2, 1'b1, -32768};
        tbl[3] = '{-32768, 2, 1'b0, 0};
        tbl[4] = '{100, -3, 1'b1, -300};
        tbl[5] = '{-200, -200, 1'b1, 32767};
        tbl[6] = '{-200, -200, 1'b0, -25536};
        tbl[7] = '{-32768, -32768, 1'b0, 0};
        tbl[8] = '{-32768, -32768, 1'b1, 32767};

        repeat (3) @(posedge clk);
        #1 chk_reset("reset");
        @(negedge clk) rstn = 1'b1;

        // 2x2 against identity
        a_cur[0:3] = '{1, 2, 3, 4};
        b_cur[0:3] = '{1, 0, 0, 1};
        sb.push_back(1); sb.push_back(2); sb.push_back(3); sb.push_back(4);
        run_mm(2, 1'b1, "run1");

        foreach (tbl[v]) begin
            a_cur[0] = tbl[v].a;
            b_cur[0] = tbl[v].b;
            sb.push_back(tbl[v].exp);
            run_mm(1, tbl[v].sat, $sformatf("vec%0d", v));
        end

        fill_rand(a_cur, b_cur);
        push_model(6, 1'b0, a_cur, b_cur);
        run_mm(6, 1'b0, "run2");

        run_mm(0, 1'b0, "n0");

        fill_rand(a_cur, b_cur);
        push_model(MAX_N, 1'b1, a_cur, b_cur);
        run_mm(MAX_N + 3, 1'b1, "nclamp");

        // Abort in LOAD_B after five B elements, then a clean 3x3 run.
        fill_rand(a_cur, b_cur);
        push_model(3, 1'b0, a_cur, b_cur);
        cur_n = 3; ak = 0; bk = 0; last_wen = -1;
        @(negedge clk);
        sizes = 4'd3; sat_en = 1'b0; start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        got = 0; cnt = 0;
        while (!got && cnt < 200) begin
            @(negedge clk);
            cnt++;
            if (state == 3'd2 && input_data_num == 5) got = 1;
        end
        chk("abort_reached_loadb_k5", got, 1);
        rstn = 1'b0;
        #1 chk_reset("abort");
        sb.delete();
        fins = 0;
        repeat (3) begin
            @(negedge clk);
            fins += finish;
        end
        rstn = 1'b1;
        repeat (3) begin
            @(negedge clk);
            fins += finish;
        end
        chk("abort_no_finish", fins, 0);
        chk("abort_stays_idle", state, 0);
        fill_rand(a_cur, b_cur);
        push_model(3, 1'b0, a_cur, b_cur);
        run_mm(3, 1'b0, "run5b");

        // start held high across two 3x3 runs; the second run sees only the new data.
        fill_rand(a_cur, b_cur);
        fill_rand(a_nxt, b_nxt);
        push_model(3, 1'b0, a_cur, b_cur);
        push_model(3, 1'b0, a_nxt, b_nxt);
        cur_n = 3; ak = 0; bk = 0; ren_cnt = 0; wen_cnt = 0; last_wen = -1;
        fin1 = 0; fin2 = 0;
        @(negedge clk);
        sizes = 4'd3; sat_en = 1'b0; start = 1'b1;
        got = 0; cnt = 0;
        while (!got && cnt < 500) begin
            @(negedge clk);
            cnt++;
            if (finish) begin got = 1; fin1 = cyc; end
        end
        chk("b2b_finish1", got, 1);
        a_cur = a_nxt; b_cur = b_nxt; ak = 0; bk = 0;
        got = 0; cnt = 0;
        while (!got && cnt < 10) begin
            @(negedge clk);
            cnt++;
            if (busy) got = 1;
        end
        chk("b2b_restart", got, 1);
        start = 1'b0;
        got = 0; cnt = 0;
        while (!got && cnt < 500) begin
            @(negedge clk);
            cnt++;
            if (finish) begin got = 1; fin2 = cyc; end
        end
        chk("b2b_finish2", got, 1);
        chk("b2b_spacing", fin2 - fin1, 57);
        chk("b2b_wen_count", wen_cnt, 18);
        chk("b2b_ren_cycles", ren_cnt, 36);
        chk("b2b_sb_left", sb.size(), 0);
        chk("b2b_out_num", out_data_num, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
